// File: rtl/rgb_lcd_rx.sv
// rgb_lcd_rx: receive side of a parallel RGB565 LCD bus (DE/HSYNC/VSYNC).
// Emits a pixel stream tagged with x/y/sof, measures frame geometry and
// declares lock once geometry repeats for LOCK_FRAMES frames.
// Ports:
//   CLK_SYS, rst (async, active-low)
//   vid_de, vid_hsync, vid_vsync, vid_r/g/b   : LCD bus sampled on CLK_SYS
//   pix_valid, pix_data, pix_x, pix_y, pix_sof : pixel stream, 2 clocks latency
//   h_active, v_active, h_total, v_total       : measured geometry
//   locked, line_mismatch, err_ovf             : status (last two sticky)
module rgb_lcd_rx #(
   parameter int CW            = 12,
   parameter int LOCK_FRAMES   = 2,
   parameter bit HS_ACTIVE_LOW = 1'b1,
   parameter bit VS_ACTIVE_LOW = 1'b1
) (
   input  logic          CLK_SYS,
   input  logic          rst,
   input  logic          vid_de,
   input  logic          vid_hsync,
   input  logic          vid_vsync,
   input  logic [4:0]    vid_r,
   input  logic [5:0]    vid_g,
   input  logic [4:0]    vid_b,
   output logic          pix_valid,
   output logic [15:0]   pix_data,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          pix_sof,
   output logic [CW-1:0] h_active,
   output logic [CW-1:0] v_active,
   output logic [CW-1:0] h_total,
   output logic [CW-1:0] v_total,
   output logic          locked,
   output logic          line_mismatch,
   output logic          err_ovf
);

   localparam logic [CW-1:0] CMAX   = '1;
   localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
   state_t state, state_d;

   logic          s1_de, s1_hs, s1_vs;
   logic [15:0]   s1_rgb;
   logic          p_de, p_hs, p_vs;
   logic          hs_start, vs_start, de_rise, de_fall;

   logic [CW-1:0] hcnt, lcnt, acnt, run, cur_y;
   logic [CW-1:0] line_total, line_act, match_cnt;
   logic [CW-1:0] prev_ha, prev_ht, prev_va, prev_vt;
   logic          prev_valid, have_line, frame_bad, sof_arm;

   logic [CW-1:0] ltot_eff, lact_eff, lcnt_eff, acnt_base, x_now, mc_inc;
   logic          bad_line, match, timeout, load, track_rst, ovf;

   function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
      return (v == CMAX) ? v : v + CW'(1);
   endfunction

   // *_eff values fold in an event landing in the same cycle as vs_start,
   // so a line closing together with the frame still counts toward it.
   always_comb begin
      hs_start  = s1_hs & ~p_hs;
      vs_start  = s1_vs & ~p_vs;
      de_rise   = s1_de & ~p_de;
      de_fall   = ~s1_de & p_de;
      x_now     = p_de ? run : '0;
      acnt_base = vs_start ? '0 : acnt;
      ltot_eff  = hs_start ? inc(hcnt) : line_total;
      lcnt_eff  = hs_start ? inc(lcnt) : lcnt;
      lact_eff  = de_fall ? run : line_act;
      bad_line  = de_fall & have_line & (run != line_act);
      match     = prev_valid & ~frame_bad & ~bad_line
                & (ltot_eff == prev_ht) & (lact_eff == prev_ha)
                & (acnt == prev_va) & (lcnt_eff == prev_vt);
      mc_inc    = inc(match_cnt);
      timeout   = ~hs_start & (hcnt == CMAX);
      ovf       = timeout
                | (hs_start & (lcnt == CMAX))
                | (de_rise & (acnt_base == CMAX))
                | (s1_de & p_de & (run == CMAX));
   end

   always_comb begin
      state_d   = state;
      load      = 1'b0;
      track_rst = 1'b0;
      if (timeout) begin
         state_d = SEARCH;
      end else if (vs_start) begin
         unique case (state)
            SEARCH: begin
               state_d   = TRACK;
               track_rst = 1'b1;
            end
            TRACK: begin
               load = 1'b1;
               if (match && (mc_inc >= LOCK_N))
                  state_d = LOCKED;
            end
            LOCKED: begin
               load = 1'b1;
               if (!match)
                  state_d = TRACK;
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge CLK_SYS or negedge rst) begin
      if (!rst) state <= SEARCH;
      else      state <= state_d;
   end

   always_ff @(posedge CLK_SYS or negedge rst) begin
      if (!rst) begin
         s1_de         <= 1'b0;
         s1_hs         <= 1'b0;
         s1_vs         <= 1'b0;
         s1_rgb        <= '0;
         p_de          <= 1'b0;
         p_hs          <= 1'b0;
         p_vs          <= 1'b0;
         pix_valid     <= 1'b0;
         pix_data      <= '0;
         pix_x         <= '0;
         pix_y         <= '0;
         pix_sof       <= 1'b0;
         h_active      <= '0;
         v_active      <= '0;
         h_total       <= '0;
         v_total       <= '0;
         locked        <= 1'b0;
         line_mismatch <= 1'b0;
         err_ovf       <= 1'b0;
         hcnt          <= '0;
         lcnt          <= '0;
         acnt          <= '0;
         run           <= '0;
         cur_y         <= '0;
         line_total    <= '0;
         line_act      <= '0;
         match_cnt     <= '0;
         prev_ha       <= '0;
         prev_ht       <= '0;
         prev_va       <= '0;
         prev_vt       <= '0;
         prev_valid    <= 1'b0;
         have_line     <= 1'b0;
         frame_bad     <= 1'b0;
         sof_arm       <= 1'b0;
      end else begin
         s1_de  <= vid_de;
         s1_hs  <= vid_hsync ^ HS_ACTIVE_LOW;
         s1_vs  <= vid_vsync ^ VS_ACTIVE_LOW;
         s1_rgb <= {vid_r, vid_g, vid_b};
         p_de   <= s1_de;
         p_hs   <= s1_hs;
         p_vs   <= s1_vs;

         pix_valid <= s1_de;
         pix_data  <= s1_rgb;
         pix_x     <= s1_de ? x_now : '0;
         pix_y     <= s1_de ? (de_rise ? acnt_base : cur_y) : '0;
         pix_sof   <= de_rise & (vs_start | sof_arm);

         // run holds DE clocks seen so far in the current run
         if (s1_de)
            run <= p_de ? inc(run) : CW'(1);

         if (de_rise) begin
            cur_y   <= acnt_base;
            acnt    <= inc(acnt_base);
            sof_arm <= 1'b0;
         end else if (vs_start) begin
            acnt    <= '0;
            sof_arm <= 1'b1;
         end

         if (hs_start) begin
            line_total <= inc(hcnt);
            hcnt       <= '0;
         end else begin
            hcnt <= inc(hcnt);
         end
         lcnt <= vs_start ? '0 : lcnt_eff;

         if (de_fall) begin
            line_act  <= run;
            have_line <= 1'b1;
            if (bad_line) begin
               frame_bad     <= 1'b1;
               line_mismatch <= 1'b1;
            end
         end
         if (vs_start) begin
            have_line <= 1'b0;
            frame_bad <= 1'b0;
         end

         if (ovf)
            err_ovf <= 1'b1;

         locked <= (state == LOCKED);

         if (timeout || track_rst) begin
            prev_valid <= 1'b0;
            match_cnt  <= '0;
         end else if (load) begin
            h_active   <= lact_eff;
            h_total    <= ltot_eff;
            v_active   <= acnt;
            v_total    <= lcnt_eff;
            prev_ha    <= lact_eff;
            prev_ht    <= ltot_eff;
            prev_va    <= acnt;
            prev_vt    <= lcnt_eff;
            prev_valid <= 1'b1;
            match_cnt  <= match ? mc_inc : '0;
         end
      end
   end

endmodule

// File: tb/tb_rgb_lcd_rx.sv
// tb_rgb_lcd_rx: random RGB565 frames against a frame-level reference model.
// dut0 sees active-low syncs, dut1 active-high syncs with identical timing.
`timescale 1ns/1ps
module tb_rgb_lcd_rx;

   localparam int CW     = 12;
   localparam int LF     = 2;
   localparam int HT     = 12;
   localparam int VT     = 7;
   localparam int HA     = 8;
   localparam int VA     = 4;
   localparam int DE_OFS = 3;
   localparam int VA_OFS = 2;

   typedef struct packed {
      logic [15:0]   d;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          sof;
   } pix_t;

   logic CLK_SYS = 1'b0;
   logic rst     = 1'b0;
   logic vid_de  = 1'b0;
   logic hs_a    = 1'b0;
   logic vs_a    = 1'b0;
   logic [4:0] vid_r = '0;
   logic [5:0] vid_g = '0;
   logic [4:0] vid_b = '0;

   logic          pv [2];
   logic [15:0]   pd [2];
   logic [CW-1:0] px [2];
   logic [CW-1:0] py [2];
   logic          ps [2];
   logic [CW-1:0] ha [2];
   logic [CW-1:0] va [2];
   logic [CW-1:0] ht [2];
   logic [CW-1:0] vt [2];
   logic          lk [2];
   logic          lm [2];
   logic          eo [2];

   int n_vec = 0;
   int n_err = 0;

   pix_t q0[$];
   pix_t q1[$];

   logic        first_red = 1'b1;
   logic        m_search, m_have_prev, m_pend, m_pend_bad;
   logic        m_locked, m_lmm, m_ovf;
   int          m_streak;
   logic [47:0] m_geo, m_prev;

   always #5 CLK_SYS = ~CLK_SYS;

   rgb_lcd_rx #(.CW(CW), .LOCK_FRAMES(LF),
                .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1)) dut0 (
      .CLK_SYS(CLK_SYS), .rst(rst), .vid_de(vid_de),
      .vid_hsync(~hs_a), .vid_vsync(~vs_a),
      .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
      .pix_valid(pv[0]), .pix_data(pd[0]), .pix_x(px[0]), .pix_y(py[0]),
      .pix_sof(ps[0]), .h_active(ha[0]), .v_active(va[0]),
      .h_total(ht[0]), .v_total(vt[0]), .locked(lk[0]),
      .line_mismatch(lm[0]), .err_ovf(eo[0]));

   rgb_lcd_rx #(.CW(CW), .LOCK_FRAMES(LF),
                .HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b0)) dut1 (
      .CLK_SYS(CLK_SYS), .rst(rst), .vid_de(vid_de),
      .vid_hsync(hs_a), .vid_vsync(vs_a),
      .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
      .pix_valid(pv[1]), .pix_data(pd[1]), .pix_x(px[1]), .pix_y(py[1]),
      .pix_sof(ps[1]), .h_active(ha[1]), .v_active(va[1]),
      .h_total(ht[1]), .v_total(vt[1]), .locked(lk[1]),
      .line_mismatch(lm[1]), .err_ovf(eo[1]));

   task automatic chk(input string name, input int k,
                      input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, got, exp);
      end
   endtask

   task automatic check_pix(input int k, input logic empty, input pix_t e);
      pix_t g;
      g = {pd[k], px[k], py[k], ps[k]};
      n_vec++;
      if (empty) begin
         n_err++;
         $display("FAIL pix dut%0d: got d=%h x=%0d y=%0d, no pixel expected",
                  k, g.d, g.x, g.y);
      end else if (g !== e) begin
         n_err++;
         $display("FAIL pix dut%0d: got d=%h x=%0d y=%0d sof=%0b, expected d=%h x=%0d y=%0d sof=%0b",
                  k, g.d, g.x, g.y, g.sof, e.d, e.x, e.y, e.sof);
      end
   endtask

   // Scoreboard monitor: pops one expected pixel per DUT pixel.
   always @(negedge CLK_SYS) begin
      logic em;
      pix_t e;
      if (rst) begin
         if (pv[0]) begin
            em = (q0.size() == 0);
            e  = '0;
            if (!em) e = q0.pop_front();
            check_pix(0, em, e);
         end
         if (pv[1]) begin
            em = (q1.size() == 0);
            e  = '0;
            if (!em) e = q1.pop_front();
            check_pix(1, em, e);
         end
      end
   end

   task automatic model_reset();
      m_search    = 1'b1;
      m_have_prev = 1'b0;
      m_pend      = 1'b0;
      m_pend_bad  = 1'b0;
      m_locked    = 1'b0;
      m_lmm       = 1'b0;
      m_ovf       = 1'b0;
      m_streak    = 0;
      m_geo       = '0;
      m_prev      = '0;
   endtask

   // Frame closed by a VSYNC start: geometry and lock per the frame rules.
   task automatic model_close();
      logic [47:0] g;
      logic        mt;
      g = {CW'(HA), CW'(VA), CW'(HT), CW'(VT)};
      if (m_search) begin
         m_search = 1'b0;
      end else if (m_pend) begin
         mt          = m_have_prev && (g == m_prev) && !m_pend_bad;
         m_streak    = mt ? m_streak + 1 : 0;
         m_locked    = (m_streak >= LF);
         m_geo       = g;
         m_prev      = g;
         m_have_prev = 1'b1;
      end
      m_pend = 1'b0;
   endtask

   task automatic drive_clk(input logic de, input logic hs, input logic vs,
                            input int x, input int y);
      logic [15:0] d;
      pix_t        e;
      @(posedge CLK_SYS);
      #1;
      vid_de = de;
      hs_a   = hs;
      vs_a   = vs;
      d      = 16'($urandom);
      if (de && first_red) begin
         d         = {5'h1F, 6'h00, 5'h00};
         first_red = 1'b0;
      end
      {vid_r, vid_g, vid_b} = d;
      if (de) begin
         e.d   = d;
         e.x   = CW'(x);
         e.y   = CW'(y);
         e.sof = (x == 0) && (y == 0);
         q0.push_back(e);
         q1.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive_clk(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic run_frame(input int bad_y, input int abort_at);
      logic old_l;
      logic de;
      int   step, y, len;
      old_l = m_locked;
      model_close();
      step = 0;
      for (int l = 0; l < VT; l++) begin
         for (int s = 0; s < HT; s++) begin
            y   = l - VA_OFS;
            len = (y == bad_y) ? HA - 1 : HA;
            de  = (y >= 0) && (y < VA) && (s >= DE_OFS) && (s < DE_OFS + len);
            drive_clk(de, s < 2, l < 2, s - DE_OFS, y);
            if (step == 2) begin
               for (int k = 0; k < 2; k++) begin
                  chk("geometry", k, {ha[k], va[k], ht[k], vt[k]}, m_geo);
                  chk("locked_hold", k, lk[k], old_l);
               end
            end
            if (step == 3) begin
               for (int k = 0; k < 2; k++) begin
                  chk("locked", k, lk[k], m_locked);
                  chk("line_mismatch", k, lm[k], m_lmm);
                  chk("err_ovf", k, eo[k], m_ovf);
               end
            end
            if (step == abort_at) return;
            step++;
         end
      end
      if (bad_y >= 0) m_lmm = 1'b1;
      m_pend     = 1'b1;
      m_pend_bad = (bad_y >= 0);
   endtask

   task automatic check_zero(input string name);
      for (int k = 0; k < 2; k++) begin
         chk({name, "_pix"}, k, {pv[k], pd[k], px[k], py[k], ps[k]}, '0);
         chk({name, "_stat"}, k,
             {ha[k], va[k], ht[k], vt[k], lk[k], lm[k], eo[k]}, '0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #3;
      check_zero("reset_state");
      @(posedge CLK_SYS);
      #1 rst = 1'b1;
      idle(4);

      // lock sequence: locks at the start of frame 4
      repeat (5) run_frame(-1, -1);
      // short line while locked, then two clean frames to relock
      run_frame(1, -1);
      repeat (3) run_frame(-1, -1);

      // HSYNC/VSYNC stop: lock held until hcnt saturates
      idle(3980);
      for (int k = 0; k < 2; k++) chk("locked_pre_timeout", k, lk[k], m_locked);
      idle(150);
      m_search    = 1'b1;
      m_have_prev = 1'b0;
      m_pend      = 1'b0;
      m_streak    = 0;
      m_locked    = 1'b0;
      m_ovf       = 1'b1;
      for (int k = 0; k < 2; k++) begin
         chk("locked_timeout", k, lk[k], 1'b0);
         chk("err_ovf_timeout", k, eo[k], 1'b1);
      end

      // relock from SEARCH, then async reset in the middle of an active line
      repeat (4) run_frame(-1, -1);
      run_frame(-1, 2 * HT + 6);
      @(negedge CLK_SYS);
      #1 rst = 1'b0;
      #1;
      check_zero("async_reset");
      q0.delete();
      q1.delete();
      model_reset();
      vid_de = 1'b0;
      hs_a   = 1'b0;
      vs_a   = 1'b0;
      repeat (3) @(posedge CLK_SYS);
      #1 rst = 1'b1;
      idle(3);

      // full lock sequence again after reset
      repeat (5) run_frame(-1, -1);
      idle(10);
      chk("leftover_q0", 0, q0.size(), 0);
      chk("leftover_q1", 1, q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rgb_lcd_rx.md
Name: rgb_lcd_rx

Overview:
- Receive side of the parallel RGB LCD interface (DE/HSYNC/VSYNC plus RGB565).
- Samples the bus on CLK_SYS (pixel clock equals CLK_SYS) and emits a pixel stream tagged with x/y coordinates and a start-of-frame marker.
- Measures frame geometry and declares lock once geometry is stable.
- Used in loopback/self-test against the LCD timing generator and as the input stage for captured-video paths.

Parameters:
CW, 12, width of all position and geometry counters
LOCK_FRAMES, 2, consecutive matching frames required for lock
HS_ACTIVE_LOW, 1, 1: HSYNC asserted at 0; 0: asserted at 1
VS_ACTIVE_LOW, 1, 1: VSYNC asserted at 0; 0: asserted at 1

Ports:
CLK_SYS  in  1  system/pixel clock
rst  in  1  reset, asynchronous, active-low
vid_de  in  1  data enable
vid_hsync  in  1  horizontal sync
vid_vsync  in  1  vertical sync
vid_r  in  5  red
vid_g  in  6  green
vid_b  in  5  blue
pix_valid  out  1  pixel qualifier
pix_data  out  16  {r,g,b} RGB565
pix_x  out  CW  pixel index within DE run
pix_y  out  CW  active-line index within frame
pix_sof  out  1  first pixel of frame
h_active  out  CW  measured DE-high clocks per line
v_active  out  CW  measured active lines per frame
h_total  out  CW  measured clocks between HSYNC starts
v_total  out  CW  measured HSYNC starts between VSYNC starts
locked  out  1  geometry stable
line_mismatch  out  1  sticky: unequal active line lengths seen within one frame
err_ovf  out  1  sticky: a counter saturated

Behaviour:
- Reset (async, rst=0):
  - All outputs 0.
  - FSM in SEARCH.
  - All counters and the stored previous geometry cleared; prev_valid=0.
- Stage 1 registers all inputs. Syncs are normalised to active-high (XOR with polarity).
- Stage 2 edge detection against the previous stage-1 sample:
  - hs_start: sync 0->1.
  - vs_start: sync 0->1.
  - de_rise, de_fall: DE 0->1 and 1->0.
- Pixel path:
  - Stage 2 drives pix_* registered: latency 2 CLK_SYS from pins to pix_valid.
  - pix_valid = stage-1 DE.
  - pix_x = 0 on the first DE clock of a run, +1 per subsequent DE clock.
  - pix_y = 0 for the first active line after vs_start; +1 on each de_rise after the first.
  - pix_sof = 1 only when pix_valid and x=0 and y=0 on the first line after vs_start.
  - The pixel stream is emitted regardless of lock state.
- Measurement:
  - h_total: hcnt counts clocks since the last hs_start. On hs_start, line_total <= hcnt+1 and hcnt <= 0.
  - h_active: on de_fall, line_act <= DE run length. A second active line in the same frame with a different length sets frame_bad and line_mismatch.
  - v_total: lcnt counts hs_start events since vs_start. v_active counts de_rise events since vs_start.
  - All counters saturate at 2^CW-1 and set err_ovf.
- Lock FSM, evaluated on vs_start:
  - SEARCH -> TRACK: on the first vs_start. The partial frame is discarded; frame counters are cleared.
  - TRACK / LOCKED, on each vs_start:
    - Frame geometry (last line_act, last line_total, active-line count, lcnt) is loaded into h_active, h_total, v_active, v_total.
    - It is compared with the stored previous geometry.
    - Match (prev_valid and equal and !frame_bad): match_cnt++. Otherwise: match_cnt <= 0.
    - The geometry is then stored; prev_valid=1.
  - TRACK -> LOCKED when match_cnt reaches LOCK_FRAMES.
  - LOCKED -> TRACK on any mismatch, with match_cnt=0.
  - locked = (state==LOCKED), registered. It changes the cycle after the vs_start detection: 3 CLK_SYS after the VSYNC pin edge.
  - Timeout: if hcnt saturates (no hs_start for 2^CW-1 clocks), any state -> SEARCH, locked=0, prev_valid=0.
- Geometry outputs hold their values between vs_start events. They update in TRACK and LOCKED only.
- Simultaneous vs_start and hs_start in the same cycle:
  - hs_start is processed first, so the line closes and counts toward the ending frame.
  - Then the frame closes.

Test Plan:
- Lock sequence: 8 active x 4 active lines, h_total 12, v_total 7, LOCK_FRAMES=2 -> h_active=8, v_active=4, h_total=12, v_total=7 after the 2nd vs_start; locked=1 3 clocks after the 4th VSYNC edge.
- Pixel path: first DE pixel R=1F, G=00, B=00 after VSYNC -> 2 clocks later pix_valid=1, pix_data=16'hF800, pix_x=0, pix_y=0, pix_sof=1; the next pixel gives pix_x=1, pix_sof=0.
- Bad line: while locked, one line has DE length 7 -> line_mismatch=1; locked=0 at the next vs_start; locked=1 again after 2 further clean frames.
- Sync timeout: HSYNC stopped while locked -> locked=0 and FSM in SEARCH after 4095 clocks (CW=12); err_ovf=1.
- Async reset: rst low mid-line -> all outputs 0 immediately with no clock edge needed; after release, the full lock sequence is repeated from SEARCH.
- Polarity: HS_ACTIVE_LOW=0, VS_ACTIVE_LOW=0 with active-high pulses of the same timing -> measurements and lock timing identical to the first scenario.
